// File: rtl/pc_sequencer.sv
// pc_sequencer: two-cycle FETCH/EXEC instruction sequencer driving an external
// program counter and logic unit. It decodes {opcode, operand} into PC commands,
// execute strobes, flag pulses and a one-shot skip.
// Optional build macro PC_SEQ_STACK_CHECK_EN adds call-depth tracking and
// sticky overflow/underflow errors that halt the sequencer.
// Ports: clk/reset (sync, active-high), run, prog_data, rr in;
//        pc_en/pc_cmd/pc_addr to the PC, exec_strobe/exec_opcode to the logic
//        unit, jmp_flag/rtn_flag/flg0/flgf pulses, busy, err_overflow/err_underflow.
module pc_sequencer #(
  parameter int ADDR_WIDTH       = 8,
  parameter int STACK_ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [ADDR_WIDTH+3:0] prog_data,
  input  logic                  rr,
  output logic                  pc_en,
  output logic [1:0]            pc_cmd,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  exec_strobe,
  output logic [3:0]            exec_opcode,
  output logic                  jmp_flag,
  output logic                  rtn_flag,
  output logic                  flg0,
  output logic                  flgf,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t state, state_next;
  logic   skip, skip_next;
  logic   stack_err;

  logic [3:0] opcode;
  assign opcode  = prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
  assign pc_addr = prog_data[ADDR_WIDTH-1:0];

  // Reset is folded in so a reset during EXEC issues nothing to the PC.
  logic in_exec;
  assign in_exec = (state == S_EXEC) && !reset;

`ifdef PC_SEQ_STACK_CHECK_EN
  logic [STACK_ADDR_WIDTH-1:0] depth;
  logic is_call, is_rtn, ovf_hit, udf_hit;
  logic ovf_q, udf_q;

  assign is_call   = in_exec && !skip && (opcode == 4'hF);
  assign is_rtn    = in_exec && !skip && (opcode == 4'hD);
  assign ovf_hit   = is_call && (depth == {STACK_ADDR_WIDTH{1'b1}});
  assign udf_hit   = is_rtn && (depth == '0);
  assign stack_err = ovf_hit || udf_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (is_call && !ovf_hit)
        depth <= depth + 1'b1;
      else if (is_rtn && !udf_hit)
        depth <= depth - 1'b1;
      if (ovf_hit) ovf_q <= 1'b1;
      if (udf_hit) udf_q <= 1'b1;
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
`else
  // Keeps the stack-width parameter referenced when depth tracking is absent.
  logic [STACK_ADDR_WIDTH-1:0] stack_unused;
  assign stack_unused  = '0;
  assign stack_err     = 1'b0;
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  // State and skip registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      skip  <= 1'b0;
    end else begin
      state <= state_next;
      skip  <= skip_next;
    end
  end

  // Next-state logic; skip survives IDLE and is only consumed by an EXEC.
  always_comb begin
    state_next = state;
    skip_next  = skip;
    case (state)
      S_IDLE:  if (run) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (stack_err)
          state_next = S_HALT;
        else if (run)
          state_next = S_FETCH;
        else
          state_next = S_IDLE;
      end
      default: state_next = S_HALT;
    endcase
    if (in_exec) begin
      if (skip)
        skip_next = 1'b0;
      else if (opcode == 4'hD && !stack_err)
        skip_next = 1'b1;     // step past the CALL word that RTN lands on
      else if (opcode == 4'hE && !rr)
        skip_next = 1'b1;
    end
  end

  // Output decode
  always_comb begin
    pc_en       = 1'b0;
    pc_cmd      = 2'b00;
    exec_strobe = 1'b0;
    exec_opcode = 4'h0;
    jmp_flag    = 1'b0;
    rtn_flag    = 1'b0;
    flg0        = 1'b0;
    flgf        = 1'b0;
    busy        = !reset && (state == S_FETCH || state == S_EXEC);
    if (in_exec) begin
      pc_en = !stack_err;
      if (!skip) begin
        case (opcode)
          4'hC: begin pc_cmd = 2'b01; jmp_flag = 1'b1; end
          4'hD: begin pc_cmd = 2'b10; rtn_flag = 1'b1; end
          4'hF: begin pc_cmd = 2'b11; flgf     = 1'b1; end
          4'hE: pc_cmd = 2'b00;
          4'h0: flg0 = 1'b1;
          default: begin
            exec_strobe = 1'b1;
            exec_opcode = opcode;
          end
        endcase
      end
    end
  end

endmodule
